k052109_scroll_counter: RTL and testbench
=========================================

// Module: k052109_scroll_counter
// PURPOSE
//  Raster position counter and scroll address generator for one tilemap layer.
//  Adds latched X/Y scroll values to the H/V beam counters using the chip's
//  ripple adder cells. Produces tile column/row and fine pixel offsets for the
//  downstream VRAM tile fetch stage.
//  Also issues a one-pixel fetch strobe at each tile boundary.
// PARAMETERS
//  H_TOTAL   384  pixels per line (ce_pix ticks), hcount wraps H_TOTAL-1 -> 0
//  H_ACTIVE  320  visible pixels per line, hcount 0..H_ACTIVE-1
//  V_TOTAL   264  lines per frame, vcount wraps V_TOTAL-1 -> 0
//  V_ACTIVE  224  visible lines, vcount 0..V_ACTIVE-1
// PORTS
//  clk        in   1  24 MHz master clock; all state on rising edge
//  reset      in   1  asynchronous, active-high reset
//  ce_pix     in   1  pixel clock enable (1 in 4 clk); all counting gated by it
//  scrx_we    in   1  CPU write strobe, X scroll shadow register
//  scry_we    in   1  CPU write strobe, Y scroll shadow register
//  scr_din    in   9  scroll write data (Y uses [7:0])
//  hcount     out  9  horizontal beam counter
//  vcount     out  9  vertical beam counter
//  hblank     out  1  high when hcount >= H_ACTIVE
//  vblank     out  1  high when vcount >= V_ACTIVE
//  tile_col   out  6  (hcount + scroll_x) [8:3], 64-column map
//  tile_row   out  5  (vcount + scroll_y) [7:3], 32-row map
//  fine_x     out  3  (hcount + scroll_x) [2:0]
//  fine_y     out  3  (vcount + scroll_y) [2:0]
//  fetch_req  out  1  one-ce_pix pulse: fetch tile at tile_col/tile_row
// BEHAVIOUR
//  - Reset: hcount=vcount=0, shadow and latched scroll=0, all address outputs 0,
//    fetch_req=0, hblank=vblank=1, FSM=S_VBLANK. Reset mid-frame aborts at once.
//  - Shadow writes: scrx_we/scry_we load scr_din on any clk (ce_pix not needed).
//  - Latch: on ce_pix with hcount==H_TOTAL-1, scroll_x_lat<=shadow_x. If also
//    vcount==V_TOTAL-1, scroll_y_lat<=shadow_y. Y is frame-latched; X is
//    line-latched. A shadow write in the latch cycle is NOT seen by the latch;
//    it applies at the next latch point.
//  - Counters: on ce_pix hcount++. At H_TOTAL-1 -> 0 and vcount++.
//    vcount wraps V_TOTAL-1 -> 0. No change without ce_pix.
//  - Sums: x_sum = hcount + scroll_x_lat, 9-bit, carry out discarded (wrap 512).
//    y_sum = vcount[7:0] + scroll_y_lat, 8-bit wrap. Build from 4/2/1-bit adder
//    cells with CI=0.
//  - Address outputs and blanks are registered on ce_pix from current counters:
//    exactly 1 ce_pix latency behind hcount/vcount.
//  - FSM, advanced on ce_pix:
//    S_VBLANK -> S_ACTIVE when wrapping into vcount==0.
//    S_ACTIVE -> S_HBLANK at hcount==H_ACTIVE-1.
//    S_HBLANK -> S_ACTIVE on line wrap if next vcount < V_ACTIVE, else S_VBLANK.
//  - fetch_req: asserted for one ce_pix period when registered fine_x==0 and
//    FSM==S_ACTIVE. Also asserted on the first active pixel of each line
//    regardless of fine_x. Never asserted in S_HBLANK or S_VBLANK.
// TESTING
//  1. Reset pulse mid-line (hcount=150) -> next clk all outputs at reset values,
//     hblank=vblank=1, fetch_req=0.
//  2. scroll_x=0, scroll_y=0, run one line -> tile_col 0..39 in order, fetch_req
//     count=40/line, hblank rises at hcount=320 (+1 ce_pix).
//  3. scroll_x=0x1FC, hcount 0..8 -> x_sum 0x1FC..0x004, tile_col 63->0 wrap,
//     fetch_req at line start and at fine_x=0.
//  4. scry_we=0xF8 mid-frame -> tile_row unchanged until frame wrap, then
//     line 0 gives tile_row=31, fine_y=0; line 8 gives tile_row=0.
//  5. scrx_we in the same clk as the line latch (hcount=383, ce_pix) -> next line
//     uses the old value; the following line uses the new value.
//  6. Full frame, ce_pix 1-in-4 -> 384*264 ce_pix per frame, vblank high exactly
//     lines 224..263, no fetch_req during vblank.

Source files
------------

// File: rtl/k052109_scroll_counter.sv
// Raster H/V beam counters with line/frame-latched scroll, ripple-cell scroll adders,
// and tile-boundary fetch strobe for one tilemap layer.
module k052109_scroll_counter #(
   parameter int unsigned H_TOTAL  = 384,
   parameter int unsigned H_ACTIVE = 320,
   parameter int unsigned V_TOTAL  = 264,
   parameter int unsigned V_ACTIVE = 224
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_pix,
   input  logic       scrx_we,
   input  logic       scry_we,
   input  logic [8:0] scr_din,
   output logic [8:0] hcount,
   output logic [8:0] vcount,
   output logic       hblank,
   output logic       vblank,
   output logic [5:0] tile_col,
   output logic [4:0] tile_row,
   output logic [2:0] fine_x,
   output logic [2:0] fine_y,
   output logic       fetch_req
);

   localparam logic [8:0] HLast    = 9'(H_TOTAL - 1);
   localparam logic [8:0] HActLast = 9'(H_ACTIVE - 1);
   localparam logic [8:0] HActive  = 9'(H_ACTIVE);
   localparam logic [8:0] VLast    = 9'(V_TOTAL - 1);
   localparam logic [8:0] VActive  = 9'(V_ACTIVE);

   typedef enum logic [1:0] {StVblank, StActive, StHblank} state_e;

   state_e     state_q, state_d;
   logic [8:0] shadow_x_q, scroll_x_q;
   logic [7:0] shadow_y_q, scroll_y_q;
   logic [8:0] x_sum, v_next;
   logic [7:0] y_sum;
   logic [4:0] xc0, xc1, yc0;
   logic [2:0] yc1, yc2;
   logic       x_carry_unused;
   logic       line_end, frame_end, fetch_d;

   function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {4'b0, ci};
   endfunction

   function automatic logic [2:0] add2(input logic [1:0] a, input logic [1:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {2'b0, ci};
   endfunction

   function automatic logic [1:0] add1(input logic a, input logic b, input logic ci);
      return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
   endfunction

   // Ripple chains: X is 4+4+1 cells, Y is 4+2+2 cells; final carries are dropped.
   always_comb begin
      xc0 = add4(hcount[3:0], scroll_x_q[3:0], 1'b0);
      xc1 = add4(hcount[7:4], scroll_x_q[7:4], xc0[4]);
      {x_carry_unused, x_sum[8]} = add1(hcount[8], scroll_x_q[8], xc1[4]);
      x_sum[7:0] = {xc1[3:0], xc0[3:0]};
      yc0 = add4(vcount[3:0], scroll_y_q[3:0], 1'b0);
      yc1 = add2(vcount[5:4], scroll_y_q[5:4], yc0[4]);
      yc2 = add2(vcount[7:6], scroll_y_q[7:6], yc1[2]);
      y_sum = {yc2[1:0], yc1[1:0], yc0[3:0]};
   end

   assign line_end  = (hcount == HLast);
   assign frame_end = line_end && (vcount == VLast);
   assign v_next    = frame_end ? 9'd0 : vcount + 9'd1;

   always_comb begin
      state_d = state_q;
      fetch_d = 1'b0;
      unique case (state_q)
         StVblank: if (frame_end) state_d = StActive;
         StActive: begin
            fetch_d = (x_sum[2:0] == 3'd0) || (hcount == 9'd0);
            if (hcount == HActLast) state_d = StHblank;
         end
         StHblank: if (line_end) state_d = (v_next < VActive) ? StActive : StVblank;
         default:  state_d = StVblank;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StVblank;
         hcount     <= 9'd0;
         vcount     <= 9'd0;
         shadow_x_q <= 9'd0;
         shadow_y_q <= 8'd0;
         scroll_x_q <= 9'd0;
         scroll_y_q <= 8'd0;
         hblank     <= 1'b1;
         vblank     <= 1'b1;
         tile_col   <= 6'd0;
         tile_row   <= 5'd0;
         fine_x     <= 3'd0;
         fine_y     <= 3'd0;
         fetch_req  <= 1'b0;
      end else begin
         if (scrx_we) shadow_x_q <= scr_din;
         if (scry_we) shadow_y_q <= scr_din[7:0];
         if (ce_pix) begin
            state_q <= state_d;
            hcount  <= line_end ? 9'd0 : hcount + 9'd1;
            if (line_end) begin
               vcount     <= v_next;
               scroll_x_q <= shadow_x_q;
            end
            if (frame_end) scroll_y_q <= shadow_y_q;
            // Registered from the pre-increment counters: one ce_pix behind hcount/vcount.
            tile_col  <= x_sum[8:3];
            fine_x    <= x_sum[2:0];
            tile_row  <= y_sum[7:3];
            fine_y    <= y_sum[2:0];
            hblank    <= (hcount >= HActive);
            vblank    <= (vcount >= VActive);
            fetch_req <= fetch_d;
         end
      end
   end

endmodule

// File: tb/tb_k052109_scroll_counter.sv
// Directed bench for k052109_scroll_counter, run with a shortened frame (20 lines, 12 active)
// so several complete frames fit in a short simulation.
module tb_k052109_scroll_counter;

   localparam int HT = 384;
   localparam int HA = 320;
   localparam int VT = 20;
   localparam int VA = 12;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ce_pix = 1'b0;
   logic       scrx_we = 1'b0;
   logic       scry_we = 1'b0;
   logic [8:0] scr_din = 9'd0;
   logic [8:0] hcount, vcount;
   logic       hblank, vblank, fetch_req;
   logic [5:0] tile_col;
   logic [4:0] tile_row;
   logic [2:0] fine_x, fine_y;

   k052109_scroll_counter #(
      .H_TOTAL (HT),
      .H_ACTIVE(HA),
      .V_TOTAL (VT),
      .V_ACTIVE(VA)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ce_pix   (ce_pix),
      .scrx_we  (scrx_we),
      .scry_we  (scry_we),
      .scr_din  (scr_din),
      .hcount   (hcount),
      .vcount   (vcount),
      .hblank   (hblank),
      .vblank   (vblank),
      .tile_col (tile_col),
      .tile_row (tile_row),
      .fine_x   (fine_x),
      .fine_y   (fine_y),
      .fetch_req(fetch_req)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int eh = 0, ev = 0;   // model counters
   int hp = 0, vp = 0;   // counter values the registered outputs now reflect

   typedef struct {
      int hpos;
      int col;
      int fx;
      int fr;
   } xvec_t;
   xvec_t xv[9];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", name, act, exp, hp, vp);
      end
   endtask

   // One ce_pix pulse followed by div-1 idle clocks; outputs sampled 1ns after the edge.
   task automatic tick(input int div);
      ce_pix = 1'b1;
      @(posedge clk);
      #1;
      ce_pix = 1'b0;
      hp = eh;
      vp = ev;
      if (eh == HT - 1) begin
         eh = 0;
         ev = (ev == VT - 1) ? 0 : ev + 1;
      end else begin
         eh++;
      end
      for (int i = 1; i < div; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_to(input int h, input int v);
      int n = 0;
      while (!(eh == h && ev == v)) begin
         tick(1);
         n++;
         if (n > HT * VT) begin
            check("run_to_bound", n, 0);
            break;
         end
      end
      check("pos_h", hcount, eh);
      check("pos_v", vcount, ev);
   endtask

   task automatic idle_write(input logic wx, input logic wy, input logic [8:0] d);
      scrx_we = wx;
      scry_we = wy;
      scr_din = d;
      @(posedge clk);
      #1;
      scrx_we = 1'b0;
      scry_we = 1'b0;
   endtask

   initial begin
      int fcnt, hbf, hb_rise, vb_err, vb_fetch, vb_lines, c0, hold;

      // x_sum from 0x1FC: wraps through 0x200 -> 0x000 at h=4
      xv[0] = '{0, 63, 4, 1};
      xv[1] = '{1, 63, 5, 0};
      xv[2] = '{2, 63, 6, 0};
      xv[3] = '{3, 63, 7, 0};
      xv[4] = '{4, 0, 0, 1};
      xv[5] = '{5, 0, 1, 0};
      xv[6] = '{6, 0, 2, 0};
      xv[7] = '{7, 0, 3, 0};
      xv[8] = '{8, 0, 4, 0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_hcount", hcount, 0);
      check("rst_vcount", vcount, 0);
      check("rst_hblank", hblank, 1);
      check("rst_vblank", vblank, 1);
      check("rst_fetch", fetch_req, 0);
      reset = 1'b0;

      // Reset mid-line
      repeat (150) tick(1);
      check("hcount_150", hcount, 150);
      check("hblank_pre", hblank, 0);
      #2 reset = 1'b1;
      #1;
      check("async_hcount", hcount, 0);
      @(posedge clk);
      #1;
      check("mid_rst_hcount", hcount, 0);
      check("mid_rst_vcount", vcount, 0);
      check("mid_rst_hblank", hblank, 1);
      check("mid_rst_vblank", vblank, 1);
      check("mid_rst_fetch", fetch_req, 0);
      check("mid_rst_col", tile_col, 0);
      check("mid_rst_finex", fine_x, 0);
      reset = 1'b0;
      eh = 0;
      ev = 0;

      // Frame after reset runs in the vblank state: no fetches at all
      fcnt = 0;
      for (int n = 0; n < HT * VT; n++) begin
         tick(1);
         fcnt += int'(fetch_req);
      end
      check("fetch_reset_frame", fcnt, 0);
      check("wrap_h", hcount, 0);
      check("wrap_v", vcount, 0);

      // Scroll 0, one active line
      fcnt = 0;
      hbf = 0;
      hb_rise = -1;
      for (int n = 0; n < HT; n++) begin
         tick(1);
         if (hp < HA) begin
            check("l0_tile_col", tile_col, hp >> 3);
            check("l0_fine_x", fine_x, hp & 7);
         end
         fcnt += int'(fetch_req);
         if (hp >= HA) hbf += int'(fetch_req);
         if (hblank && hb_rise < 0) hb_rise = hp;
      end
      check("l0_fetch_count", fcnt, 40);
      check("l0_hblank_fetch", hbf, 0);
      check("l0_hblank_rise", hb_rise, HA);

      // X scroll 0x1FC, applied from the next line latch
      idle_write(1'b1, 1'b0, 9'h1FC);
      tick(1);
      check("x_not_yet_col", tile_col, 0);
      run_to(0, 2);
      foreach (xv[i]) begin
         tick(1);
         check("xwrap_h", hp, xv[i].hpos);
         check("xwrap_col", tile_col, xv[i].col);
         check("xwrap_finex", fine_x, xv[i].fx);
         check("xwrap_fetch", fetch_req, xv[i].fr);
      end

      // X write coinciding with the line latch
      run_to(HT - 1, 2);
      scrx_we = 1'b1;
      scr_din = 9'h010;
      tick(1);
      scrx_we = 1'b0;
      tick(1);
      check("latch_old_col", tile_col, 63);
      check("latch_old_finex", fine_x, 4);
      run_to(0, 4);
      tick(1);
      check("latch_new_col", tile_col, 2);
      check("latch_new_finex", fine_x, 0);
      check("latch_new_fetch", fetch_req, 1);

      // Y scroll 0xF8 written mid-frame, frame-latched
      idle_write(1'b0, 1'b1, 9'h0F8);
      tick(1);
      check("y_old_row", tile_row, 0);
      check("y_old_finey", fine_y, 4);
      run_to(0, 0);
      tick(1);
      check("y_l0_row", tile_row, 31);
      check("y_l0_finey", fine_y, 0);
      run_to(0, 1);
      tick(1);
      check("y_l1_row", tile_row, 31);
      check("y_l1_finey", fine_y, 1);
      run_to(0, 8);
      tick(1);
      check("y_l8_row", tile_row, 0);
      check("y_l8_finey", fine_y, 0);

      // Full frame with ce_pix 1 in 4
      run_to(0, 0);
      c0 = cyc;
      fcnt = 0;
      vb_err = 0;
      vb_fetch = 0;
      vb_lines = 0;
      for (int n = 0; n < HT * VT; n++) begin
         tick(4);
         if (int'(vblank) != int'(vp >= VA)) vb_err++;
         if (vblank) vb_fetch += int'(fetch_req);
         if (vblank && hp == 0) vb_lines++;
         fcnt += int'(fetch_req);
      end
      check("frame_cycles", cyc - c0, 4 * HT * VT);
      check("frame_vblank_err", vb_err, 0);
      check("frame_vblank_lines", vb_lines, VT - VA);
      check("frame_vblank_fetch", vb_fetch, 0);
      check("frame_fetch_total", fcnt, 40 * VA);
      check("frame_end_h", hcount, 0);
      check("frame_end_v", vcount, 0);

      // Counters hold without ce_pix
      tick(1);
      hold = hcount;
      repeat (3) @(posedge clk);
      #1;
      check("hold_no_ce", hcount, eh);
      check("hold_value", hold, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
